// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_pkg
// Purpose  : Shared definitions for the bit-serial subtractor slice:
//            default operand width, FSM state encoding and a helper that
//            sizes the bit counter from the operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int c_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int c_CNT_W_DEF = cnt_width(c_WIDTH_DEF);

endpackage
`default_nettype wire

// File: rtl/fullSubtractor.sv
`default_nettype none
// ============================================================================
// Module   : fullSubtractor
// Purpose  : 1-bit full-subtractor cell, D = A - B - Bin.
// Ports    : A, B, Bin (in)  - minuend bit, subtrahend bit, borrow-in
//            D, Bout   (out) - difference bit, borrow-out
// Revision : 1.0 - initial release
// ============================================================================
module fullSubtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    // Borrow when B exceeds A outright, or when they tie and a borrow is pending.
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule
`default_nettype wire

// File: rtl/four_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_serial_subtractor
// Purpose  : Bit-serial subtractor, D = (A - B - Bin) mod 2^WIDTH, one bit
//            per clock, LSB first, using a single full-subtractor cell and a
//            registered borrow. start/busy/done handshake.
// Ports    : clk, rst (async, active-high), start, A, B, Bin (in)
//            busy, done, D, Bout (out); V (out, only with SUB_OVERFLOW_EN)
// Options  : SUB_OVERFLOW_EN - adds registered signed-overflow output V.
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int                 c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    // Only WIDTH-1 earlier bits need storing: the MSB is produced on the
    // final edge and goes straight into the result register.
    logic [WIDTH-2:0]   r_d_sr;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_d;
    logic               r_bout;

    logic               w_d;
    logic               w_bnext;

    fullSubtractor u_fs (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Bin  (r_borrow),
        .D    (w_d),
        .Bout (w_bnext)
    );

    assign w_last = (r_state == S_SHIFT) && (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Back-to-back: a start seen here reloads without idling.
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, borrow, counter, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else if (w_load) begin
            r_a_sr   <= A;
            r_b_sr   <= B;
            r_d_sr   <= '0;
            r_borrow <= Bin;
            r_cnt    <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_d_sr   <= {w_d, r_d_sr[WIDTH-2:1]};
            r_borrow <= w_bnext;
            r_cnt    <= r_cnt + c_CNT_ONE;
            if (w_last) begin
                r_d    <= {w_d, r_d_sr};
                r_bout <= w_bnext;
            end
        end
    end

    assign D    = r_d;
    assign Bout = r_bout;

`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are shifted out during SHIFT, so keep copies.
    logic r_a_msb;
    logic r_b_msb;
    logic r_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end else if (w_last) begin
            // Signs differ and the result sign departs from the minuend's.
            r_v <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
        end
    end

    assign V = r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_four_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_bit_serial_subtractor
// Purpose  : Self-checking bench for four_bit_serial_subtractor. Expected
//            results are queued at issue time and popped by an independent
//            monitor whenever done is presented.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_four_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       bout;
`ifdef SUB_OVERFLOW_EN
    logic       v;
`endif

    typedef struct packed {
        logic [3:0] d;
        logic       bout;
        logic       v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    four_bit_serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (d),
        .Bout  (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .V     (v)
`endif
    );

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic bi);
        int   diff;
        int   sdiff;
        exp_t e;
        diff   = int'(x) - int'(y) - int'(bi);
        e.d    = 4'(diff & 15);
        e.bout = (diff < 0);
        sdiff  = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.v    = (sdiff < -8) || (sdiff > 7);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [3:0] prev_d;
    logic       prev_bout;
    logic       prev_done;
    exp_t       m_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_d    = d;
            prev_bout = bout;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("busy_low_in_done", busy, 0);
                check("done_single_cycle", prev_done, 0);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    m_e = q.pop_front();
                    check("D", d, m_e.d);
                    check("Bout", bout, m_e.bout);
`ifdef SUB_OVERFLOW_EN
                    check("V", v, m_e.v);
`endif
                end
            end else begin
                check("D_stable", d, prev_d);
                check("Bout_stable", bout, prev_bout);
            end
            prev_d    = d;
            prev_bout = bout;
            prev_done = done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic op(input logic [3:0] x, input logic [3:0] y, input logic bi);
        int nb;
        bit seen;
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        q.push_back(model(x, y, bi));
        @(negedge clk);
        start = 1'b0;
        nb    = 0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        check("done_seen", seen, 1);
        check("busy_cycles", nb, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gap;
        bit  seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_D", d, 0);
        check("rst_Bout", bout, 0);
`ifdef SUB_OVERFLOW_EN
        check("rst_V", v, 0);
`endif
        rst = 1'b0;

        op(4'd9, 4'd3, 1'b0);
        op(4'd3, 4'd9, 1'b0);
        op(4'd0, 4'd0, 1'b1);
        op(4'd8, 4'd1, 1'b0);
        op(4'd5, 4'd2, 1'b0);
        op(4'd15, 4'd15, 1'b1);
        op(4'd7, 4'd8, 1'b0);

        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // start held high: operands changed mid-SHIFT must be ignored, and
        // the second operation is accepted in the DONE cycle.
        @(negedge clk);
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        q.push_back(model(4'd7, 4'd2, 1'b0));
        q.push_back(model(4'd12, 4'd5, 1'b1));
        repeat (2) @(negedge clk);
        a = 4'd12; b = 4'd5; bin = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("held_first_done", seen, 1);
        @(negedge clk);
        start = 1'b0;
        check("held_restart_busy", busy, 1);
        gap  = 1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            gap++;
            @(negedge clk);
        end
        check("held_second_done", seen, 1);
        check("held_throughput", gap, 5);

        // Reset during SHIFT aborts without producing done.
        @(negedge clk);
        a = 4'd6; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_D", d, 0);
        check("abort_Bout", bout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        op(4'd4, 4'd4, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
